prism_cfg_loader: RTL and testbench
===================================

Name: prism_cfg_loader

Overview:
- Sequencer/arbiter that owns the PRISM debug write port (32-bit writes, 6-bit byte address).
- Bulk-loads a block of configuration words from a valid/ready stream and passes host (TinyQV) writes through when idle.
- Brackets each load: holds the FSM in reset/disabled, waits for halt, writes words spaced by a gap, then releases and optionally re-arms the FSM.
- Sits between the peripheral bus decode and the PRISM debug/latch-register write path.

Parameters:
WR_GAP, 2, idle cycles after each debug write; covers the 2-stage delayed latch-register write.
HALT_TIMEOUT, 15, max cycles waiting for prism_halt in HALT state (4-bit timer).
ADDR_W, 6, debug byte-address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
host_addr  in  ADDR_W  host write address
host_wdata  in  32  host write data
host_wr  in  1  host 32-bit write strobe
host_busy  out  1  loader owns the port (state != IDLE)
ld_start  in  1  start pulse, sampled in IDLE only
ld_base  in  ADDR_W  first word address
ld_count  in  5  number of words (0..16)
ld_autorun  in  1  request FSM run after load
ld_data  in  32  stream word
ld_valid  in  1  stream valid
ld_ready  out  1  stream ready
dbg_addr  out  ADDR_W  registered debug address
dbg_wdata  out  32  registered debug data
dbg_wr  out  1  registered debug write strobe
dbg_rdata  in  32  debug read data (used only with verify option)
prism_halt  in  1  PRISM halted indication
fsm_hold  out  1  forces PRISM reset=1/enable=0 while high
fsm_run  out  1  one-cycle pulse: set PRISM enable
ld_done  out  1  one-cycle completion pulse (success or error)
err  out  4  sticky {verify, conflict, timeout, cfg}
err_clr  in  1  clears err

Behaviour:
- Reset: state IDLE; dbg_addr=0, dbg_wdata=0, dbg_wr=0, ld_ready=0, fsm_hold=0, fsm_run=0, ld_done=0, err=0, host_busy=0. Reset mid-load aborts immediately; no further writes.
- States: IDLE, HALT, LOAD, GAP, RELEASE.
- IDLE: host_wr -> next cycle dbg_wr=1, dbg_addr=host_addr, dbg_wdata=host_wdata (1-cycle latency). ld_start with host_wr in same cycle: host write is forwarded, load starts same cycle.
- Start checks in IDLE: ld_base[1:0]!=0 or ld_base+4*ld_count>64 -> err[0]=1, ld_done pulse next cycle, stay IDLE. ld_count==0 -> ld_done next cycle, no writes, fsm_hold untouched.
- HALT: fsm_hold=1; timer counts from 0; prism_halt=1 -> LOAD. Timer reaches HALT_TIMEOUT without halt -> err[1]=1, fsm_hold=0, ld_done, IDLE.
- LOAD: ld_ready=1; ld_valid&ld_ready -> dbg_wr=1 next cycle, dbg_addr=ld_base+4*idx, dbg_wdata=ld_data; idx++ -> GAP. ld_valid low: wait indefinitely.
- GAP: ld_ready=0, dbg_wr=0 for WR_GAP cycles; then LOAD if idx<ld_count, else RELEASE.
- RELEASE (1 cycle): fsm_hold=0; fsm_run=ld_autorun (latched at start); ld_done=1; -> IDLE.
- ld_base, ld_count, ld_autorun latched on accepted start; later changes ignored.
- Busy (state != IDLE): host_wr dropped, err[2]=1; ld_start ignored.
- Address arithmetic mod 2^ADDR_W; the cfg check guarantees no wrap occurs.
- err_clr clears all bits; a same-cycle set wins over clear.

Optional Feature:
PRISM_LOADER_VERIFY_EN: in the last GAP cycle, dbg_addr is held at the written address; dbg_rdata is compared with the written word; mismatch sets err[3] and continues the load. Without the macro, dbg_rdata is unused and err[3] is tied 0.

Test Plan:
- Host pass-through: IDLE, host_wr addr 0x20 data 0x00AB1234 -> next cycle dbg_wr=1, dbg_addr=0x20, dbg_wdata=0x00AB1234.
- Load 3 words: base 0x08, count 3, autorun=1, halt after 2 cycles -> writes 0x08, 0x0C, 0x10 spaced WR_GAP+1 cycles apart, then fsm_hold falls, fsm_run=1 and ld_done=1 for one cycle.
- Bad cfg: base 0x3C, count 2 -> err=0001, ld_done pulse, no dbg_wr, fsm_hold stays 0.
- Halt timeout: prism_halt held 0 -> after 15 cycles err=0010, ld_done, no writes.
- Conflict and stall: host_wr during LOAD with ld_valid stalled 5 cycles -> err=0100, host write never reaches dbg port, load completes after valid returns.
- Reset mid-load after first write -> all outputs 0 next edge; subsequent ld_start runs cleanly from word 0.

Source files
------------

// File: rtl/prism_cfg_loader.sv
// PRISM debug-port sequencer: bulk config loads from a stream, host pass-through when idle.
// Optional read-back verify of each written word: define PRISM_LOADER_VERIFY_EN.
module prism_cfg_loader #(
    parameter int WR_GAP       = 2,
    parameter int HALT_TIMEOUT = 15,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    input  logic              host_wr,
    output logic              host_busy,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [4:0]        ld_count,
    input  logic              ld_autorun,
    input  logic [31:0]       ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_wdata,
    output logic              dbg_wr,
    input  logic [31:0]       dbg_rdata,
    input  logic              prism_halt,
    output logic              fsm_hold,
    output logic              fsm_run,
    output logic              ld_done,
    output logic [3:0]        err,
    input  logic              err_clr
);

    localparam int EW = ADDR_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_LOAD,
        S_GAP,
        S_RELEASE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        count_q;
    logic [4:0]        idx_q;
    logic              autorun_q;
    logic [3:0]        timer_q;
    logic [3:0]        gap_q;
    logic              done_q;
    logic [3:0]        err_q;
    logic [3:0]        err_set;
    logic [EW-1:0]     end_addr;
    logic              cfg_bad;
    logic              gap_last;
    logic              timeout;

    // Wide sum so an oversized count cannot alias back into range.
    assign end_addr = EW'(ld_base) + (EW'(ld_count) << 2);
    assign cfg_bad  = (ld_base[1:0] != 2'b00) || (end_addr > EW'(1 << ADDR_W));
    assign gap_last = (gap_q == 4'(WR_GAP - 1));
    assign timeout  = (timer_q == 4'(HALT_TIMEOUT - 1));

`ifdef PRISM_LOADER_VERIFY_EN
    logic verify_bad;
    assign verify_bad = (state == S_GAP) && gap_last && (dbg_rdata != dbg_wdata);
`else
    logic unused_rdata;
    assign unused_rdata = ^dbg_rdata;
`endif

    always_comb begin
        state_d = state;
        err_set = 4'b0000;
        unique case (state)
            S_IDLE: begin
                if (ld_start && cfg_bad) begin
                    err_set[0] = 1'b1;
                end else if (ld_start && (ld_count != 5'd0)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (prism_halt) begin
                    state_d = S_LOAD;
                end else if (timeout) begin
                    state_d    = S_IDLE;
                    err_set[1] = 1'b1;
                end
            end
            S_LOAD: begin
                if (ld_valid) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_d = (idx_q < count_q) ? S_LOAD : S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (state != S_IDLE && host_wr) err_set[2] = 1'b1;
`ifdef PRISM_LOADER_VERIFY_EN
        if (verify_bad) err_set[3] = 1'b1;
`endif
    end

    assign host_busy = (state != S_IDLE);
    assign ld_ready  = (state == S_LOAD);
    assign fsm_hold  = (state == S_HALT) || (state == S_LOAD) || (state == S_GAP);
    assign fsm_run   = (state == S_RELEASE) && autorun_q;
    assign ld_done   = (state == S_RELEASE) || done_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dbg_addr  <= '0;
            dbg_wdata <= '0;
            dbg_wr    <= 1'b0;
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            autorun_q <= 1'b0;
            timer_q   <= '0;
            gap_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state  <= state_d;
            dbg_wr <= 1'b0;
            done_q <= 1'b0;
            err_q  <= (err_clr ? 4'b0000 : err_q) | err_set;
            unique case (state)
                S_IDLE: begin
                    if (host_wr) begin
                        dbg_wr    <= 1'b1;
                        dbg_addr  <= host_addr;
                        dbg_wdata <= host_wdata;
                    end
                    if (ld_start) begin
                        if (cfg_bad || ld_count == 5'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            base_q    <= ld_base;
                            count_q   <= ld_count;
                            autorun_q <= ld_autorun;
                            idx_q     <= '0;
                            timer_q   <= '0;
                        end
                    end
                end
                S_HALT: begin
                    timer_q <= timer_q + 4'd1;
                    if (!prism_halt && timeout) done_q <= 1'b1;
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        dbg_wr    <= 1'b1;
                        dbg_addr  <= base_q + (ADDR_W'(idx_q) << 2);
                        dbg_wdata <= ld_data;
                        idx_q     <= idx_q + 5'd1;
                        gap_q     <= '0;
                    end
                end
                S_GAP: gap_q <= gap_q + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Directed bench for prism_cfg_loader: pass-through, loads, error paths, reset abort.
module tb_prism_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_wr;
    logic        host_busy;
    logic        ld_start;
    logic [5:0]  ld_base;
    logic [4:0]  ld_count;
    logic        ld_autorun;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_wr;
    logic [31:0] dbg_rdata;
    logic        prism_halt;
    logic        fsm_hold;
    logic        fsm_run;
    logic        ld_done;
    logic [3:0]  err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    // Ideal memory: read-back echoes the last written word.
    assign dbg_rdata = dbg_wdata;

    always #5 clk = ~clk;

    prism_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_wr    (host_wr),
        .host_busy  (host_busy),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_count   (ld_count),
        .ld_autorun (ld_autorun),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_wr     (dbg_wr),
        .dbg_rdata  (dbg_rdata),
        .prism_halt (prism_halt),
        .fsm_hold   (fsm_hold),
        .fsm_run    (fsm_run),
        .ld_done    (ld_done),
        .err        (err),
        .err_clr    (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered with the DUT in LOAD; streams n words and checks the release.
    task automatic do_words(input logic [5:0] base, input int n,
                            input logic autorun, input logic [31:0] seed);
        logic [5:0] ea;
        for (int i = 0; i < n; i++) begin
            ea       = base + 6'(4 * i);
            ld_valid = 1'b1;
            ld_data  = seed + 32'(i);
            tick();
            ld_valid = 1'b0;
            chk("wr_strobe", 64'(dbg_wr), 64'd1);
            chk("wr_addr", 64'(dbg_addr), 64'(ea));
            chk("wr_data", 64'(dbg_wdata), 64'(seed + 32'(i)));
            tick();
            chk("gap_wr", 64'(dbg_wr), 64'd0);
            chk("gap_ready", 64'(ld_ready), 64'd0);
            chk("gap_hold", 64'(fsm_hold), 64'd1);
            tick();
            if (i < n - 1) begin
                chk("reload_ready", 64'(ld_ready), 64'd1);
            end else begin
                chk("rel_hold", 64'(fsm_hold), 64'd0);
                chk("rel_run", 64'(fsm_run), 64'(autorun));
                chk("rel_done", 64'(ld_done), 64'd1);
            end
        end
        tick();
        chk("post_done", 64'(ld_done), 64'd0);
        chk("post_run", 64'(fsm_run), 64'd0);
        chk("post_busy", 64'(host_busy), 64'd0);
    endtask

    task automatic start(input logic [5:0] base, input logic [4:0] cnt,
                         input logic autorun);
        ld_base    = base;
        ld_count   = cnt;
        ld_autorun = autorun;
        ld_start   = 1'b1;
        tick();
        ld_start   = 1'b0;
    endtask

    initial begin
        int  n;
        int  wrs;
        logic done;

        rst_n      = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_wr    = 1'b0;
        ld_start   = 1'b0;
        ld_base    = '0;
        ld_count   = '0;
        ld_autorun = 1'b0;
        ld_data    = '0;
        ld_valid   = 1'b0;
        prism_halt = 1'b0;
        err_clr    = 1'b0;
        tick();
        tick();
        chk("rst_wr", 64'(dbg_wr), 64'd0);
        chk("rst_addr", 64'(dbg_addr), 64'd0);
        chk("rst_data", 64'(dbg_wdata), 64'd0);
        chk("rst_ready", 64'(ld_ready), 64'd0);
        chk("rst_hold", 64'(fsm_hold), 64'd0);
        chk("rst_run", 64'(fsm_run), 64'd0);
        chk("rst_done", 64'(ld_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(host_busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Host pass-through
        host_addr  = 6'h20;
        host_wdata = 32'h00AB1234;
        host_wr    = 1'b1;
        tick();
        host_wr = 1'b0;
        chk("host_wr", 64'(dbg_wr), 64'd1);
        chk("host_addr", 64'(dbg_addr), 64'h20);
        chk("host_data", 64'(dbg_wdata), 64'h00AB1234);
        tick();
        chk("host_wr_pulse", 64'(dbg_wr), 64'd0);

        // Three-word load with autorun; base changed after start is ignored
        start(6'h08, 5'd3, 1'b1);
        ld_base  = 6'h30;
        ld_count = 5'd1;
        chk("halt_hold", 64'(fsm_hold), 64'd1);
        chk("halt_busy", 64'(host_busy), 64'd1);
        chk("halt_ready", 64'(ld_ready), 64'd0);
        tick();
        prism_halt = 1'b1;
        tick();
        chk("load_ready", 64'(ld_ready), 64'd1);
        do_words(6'h08, 3, 1'b1, 32'hC0DE0000);
        chk("load3_err", 64'(err), 64'd0);
        prism_halt = 1'b0;

        // Bad cfg: 0x3C + 8 overruns the window
        start(6'h3C, 5'd2, 1'b0);
        chk("cfg_done", 64'(ld_done), 64'd1);
        chk("cfg_err", 64'(err), 64'b0001);
        chk("cfg_wr", 64'(dbg_wr), 64'd0);
        chk("cfg_hold", 64'(fsm_hold), 64'd0);
        chk("cfg_busy", 64'(host_busy), 64'd0);
        tick();
        chk("cfg_done_pulse", 64'(ld_done), 64'd0);
        err_clr = 1'b1;
        tick();
        chk("clr_err", 64'(err), 64'd0);
        // Misaligned base with a simultaneous clear: set wins
        start(6'h02, 5'd1, 1'b0);
        err_clr = 1'b0;
        chk("misalign_err", 64'(err), 64'b0001);
        chk("misalign_done", 64'(ld_done), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Zero-count load
        start(6'h00, 5'd0, 1'b1);
        chk("zero_done", 64'(ld_done), 64'd1);
        chk("zero_hold", 64'(fsm_hold), 64'd0);
        chk("zero_busy", 64'(host_busy), 64'd0);
        chk("zero_err", 64'(err), 64'd0);
        chk("zero_wr", 64'(dbg_wr), 64'd0);

        // Halt timeout
        start(6'h00, 5'd1, 1'b1);
        chk("to_hold", 64'(fsm_hold), 64'd1);
        n    = 0;
        wrs  = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            n++;
            if (dbg_wr) wrs++;
            if (ld_done) done = 1'b1;
        end
        chk("to_seen", 64'(done), 64'd1);
        chk("to_cycles", 64'(n), 64'd15);
        chk("to_err", 64'(err), 64'b0010);
        chk("to_hold_rel", 64'(fsm_hold), 64'd0);
        chk("to_writes", 64'(wrs), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Host conflict during a stalled LOAD
        prism_halt = 1'b1;
        start(6'h10, 5'd2, 1'b0);
        tick();
        chk("st_ready", 64'(ld_ready), 64'd1);
        host_addr  = 6'h04;
        host_wdata = 32'hDEADBEEF;
        wrs = 0;
        for (int k = 0; k < 5; k++) begin
            host_wr = 1'b1;
            tick();
            if (dbg_wr) wrs++;
        end
        host_wr = 1'b0;
        chk("st_writes", 64'(wrs), 64'd0);
        chk("st_err", 64'(err), 64'b0100);
        chk("st_still_ready", 64'(ld_ready), 64'd1);
        do_words(6'h10, 2, 1'b0, 32'h5A5A0010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset after the first write of a load, then a clean rerun
        start(6'h20, 5'd2, 1'b1);
        tick();
        ld_valid = 1'b1;
        ld_data  = 32'h11110000;
        tick();
        ld_valid = 1'b0;
        chk("ab_first_wr", 64'(dbg_wr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ab_wr", 64'(dbg_wr), 64'd0);
        chk("ab_addr", 64'(dbg_addr), 64'd0);
        chk("ab_hold", 64'(fsm_hold), 64'd0);
        chk("ab_busy", 64'(host_busy), 64'd0);
        chk("ab_ready", 64'(ld_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start(6'h20, 5'd2, 1'b1);
        tick();
        do_words(6'h20, 2, 1'b1, 32'h22220000);
        chk("final_err", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
